// File: rtl/counter_drv_pkg.sv
// Shared definitions for the 74192 pulse driver: command encoding, FSM state codes
// and default timing.
package counter_drv_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_UP    = 2'b10,
        OP_DOWN  = 2'b11
    } cmd_op_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_CLR       = 3'd1;
    localparam state_t ST_LOAD      = 3'd2;
    localparam state_t ST_LOAD_HOLD = 3'd3;
    localparam state_t ST_P_LO      = 3'd4;
    localparam state_t ST_P_HI      = 3'd5;

    localparam int DEF_PULSE_LO = 2;
    localparam int DEF_PULSE_HI = 2;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/tc_edge_detect.sv
// Brings an active-low terminal-count return into the clock domain and flags each
// falling edge with a one-cycle pulse.
module tc_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic tc_n_i,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic last_q;
    logic fall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            last_q  <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= tc_n_i;
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
            fall_q  <= last_q & ~sync2_q;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/counter_pulse_driver.sv
// Command-driven pulse generator for a 74192 up/down BCD counter: clear, parallel
// load and bursts of count pulses, plus carry/borrow event detection.
module counter_pulse_driver
    import counter_drv_pkg::*;
#(
    parameter int PULSE_LO = DEF_PULSE_LO,
    parameter int PULSE_HI = DEF_PULSE_HI
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic       done,
    output logic       err,
    output logic       UP,
    output logic       DN,
    output logic       PL,
    output logic       MR,
    output logic [3:0] D,
    input  logic       TCU,
    input  logic       TCD,
    output logic       carry_evt,
    output logic       borrow_evt,
    output state_t     dbg_state_o
);

    localparam logic [3:0] LO_LAST = 4'(PULSE_LO - 1);
    localparam logic [3:0] HI_LAST = 4'(PULSE_HI - 1);

    state_t     state_q, state_d;
    logic [3:0] timer_q, timer_d;
    logic [3:0] cnt_q, cnt_d;
    logic       dir_dn_q, dir_dn_d;
    logic [3:0] d_q, d_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       up_q, dn_q, pl_q, mr_q;
    logic       accept;

    // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready
    // are both 1; op/data are captured only then. cmd_valid while busy is dropped.
    assign cmd_ready = rst_n && (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        dir_dn_d = dir_dn_q;
        d_d      = d_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_CLEAR: begin
                            state_d = ST_CLR;
                            timer_d = HI_LAST;
                        end
                        OP_LOAD: begin
                            if (cmd_data <= BCD_MAX) begin
                                state_d = ST_LOAD;
                                timer_d = LO_LAST;
                                d_d     = cmd_data;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: begin
                            if (cmd_data == 4'd0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d  = ST_P_LO;
                                timer_d  = LO_LAST;
                                cnt_d    = cmd_data;
                                dir_dn_d = (cmd_op == OP_DOWN);
                            end
                        end
                    endcase
                end
            end
            ST_CLR: begin
                if (timer_q == 4'd0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            ST_LOAD: begin
                if (timer_q == 4'd0) state_d = ST_LOAD_HOLD;
                else                 timer_d = timer_q - 4'd1;
            end
            ST_LOAD_HOLD: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            ST_P_LO: begin
                if (timer_q == 4'd0) begin
                    state_d = ST_P_HI;
                    timer_d = HI_LAST;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            ST_P_HI: begin
                if (timer_q != 4'd0) begin
                    timer_d = timer_q - 4'd1;
                end else begin
                    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_P_LO;
                        timer_d = LO_LAST;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // PL/MR follow the next state; count pins are retimed from the current state,
    // so each UP/DN pulse trails its P_LO state by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= 4'd0;
            cnt_q    <= 4'd0;
            dir_dn_q <= 1'b0;
            d_q      <= 4'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            up_q     <= 1'b1;
            dn_q     <= 1'b1;
            pl_q     <= 1'b0;
            mr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            dir_dn_q <= dir_dn_d;
            d_q      <= d_d;
            done_q   <= done_d;
            err_q    <= err_d;
            up_q     <= !((state_q == ST_P_LO) && !dir_dn_q);
            dn_q     <= !((state_q == ST_P_LO) && dir_dn_q);
            pl_q     <= (state_d == ST_LOAD);
            mr_q     <= (state_d == ST_CLR);
        end
    end

    tc_edge_detect u_tcu_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .tc_n_i (TCU),
        .fall_o (carry_evt)
    );

    tc_edge_detect u_tcd_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .tc_n_i (TCD),
        .fall_o (borrow_evt)
    );

    assign done        = done_q;
    assign err         = err_q;
    assign UP          = up_q;
    assign DN          = dn_q;
    assign PL          = pl_q;
    assign MR          = mr_q;
    assign D           = d_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_counter_pulse_driver.sv
// Directed bench for counter_pulse_driver: per-cycle vector table, corner-case
// sequences and a closed loop against a behavioural 74192.
module tb_counter_pulse_driver;
    import counter_drv_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic       done, err, UP, DN, PL, MR;
    logic [3:0] D;
    logic       TCU, TCD;
    logic       carry_evt, borrow_evt;
    state_t     dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    counter_pulse_driver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .done        (done),
        .err         (err),
        .UP          (UP),
        .DN          (DN),
        .PL          (PL),
        .MR          (MR),
        .D           (D),
        .TCU         (TCU),
        .TCD         (TCD),
        .carry_evt   (carry_evt),
        .borrow_evt  (borrow_evt),
        .dbg_state_o (dbg_state)
    );

    // Terminal-count sources: either driven directly or from the 74192 model
    logic       tc_model = 1'b0;
    logic       tcu_drv  = 1'b1;
    logic       tcd_drv  = 1'b1;
    logic [3:0] q_m      = 4'd0;
    logic       up_prev  = 1'b1;
    logic       dn_prev  = 1'b1;

    assign TCU = tc_model ? !((q_m == 4'd9) && !UP) : tcu_drv;
    assign TCD = tc_model ? !((q_m == 4'd0) && !DN) : tcd_drv;

    always @(posedge clk) begin
        if (tc_model) begin
            if (MR)                   q_m <= 4'd0;
            else if (PL)              q_m <= D;
            else if (!up_prev && UP)  q_m <= (q_m == 4'd9) ? 4'd0 : q_m + 4'd1;
            else if (!dn_prev && DN)  q_m <= (q_m == 4'd0) ? 4'd9 : q_m - 4'd1;
        end
        up_prev <= UP;
        dn_prev <= DN;
    end

    int carry_cnt  = 0;
    int borrow_cnt = 0;

    always @(negedge clk) begin
        if (carry_evt)  carry_cnt  <= carry_cnt + 1;
        if (borrow_evt) borrow_cnt <= borrow_cnt + 1;
    end

    typedef struct {
        logic       in_valid;
        logic [1:0] in_op;
        logic [3:0] in_data;
        logic       exp_up;
        logic       exp_dn;
        logic       exp_pl;
        logic       exp_mr;
        logic [3:0] exp_d;
        logic       exp_done;
        logic       exp_err;
        logic       exp_ready;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] exp_q[$];

    function automatic vec_t mk(input logic v, input logic [1:0] op, input logic [3:0] data,
                                input logic up, input logic dn, input logic pl, input logic mr,
                                input logic [3:0] d, input logic dn_e, input logic er,
                                input logic rdy);
        vec_t r;
        r.in_valid  = v;
        r.in_op     = op;
        r.in_data   = data;
        r.exp_up    = up;
        r.exp_dn    = dn;
        r.exp_pl    = pl;
        r.exp_mr    = mr;
        r.exp_d     = d;
        r.exp_done  = dn_e;
        r.exp_err   = er;
        r.exp_ready = rdy;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] data);
        chk1("send_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk1({name, "_done"}, seen, 1'b1);
    endtask

    task automatic run_closed(input string name, input logic [1:0] op, input logic [3:0] data);
        send(op, data);
        wait_done(name, 100);
        chk4({name, "_q"}, q_m, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0, b0;
        logic bad;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_CLEAR;
        cmd_data  = 4'd0;

        // Reset
        repeat (3) step();
        chk1("rst_up", UP, 1'b1);
        chk1("rst_dn", DN, 1'b1);
        chk1("rst_pl", PL, 1'b0);
        chk1("rst_mr", MR, 1'b0);
        chk4("rst_d", D, 4'd0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_carry", carry_evt, 1'b0);
        chk1("rst_borrow", borrow_evt, 1'b0);
        chk1("rst_ready", cmd_ready, 1'b0);
        chk1("rst_state_idle", dbg_state == ST_IDLE, 1'b1);
        rst_n = 1'b1;
        step();
        chk1("ready_after_rst", cmd_ready, 1'b1);

        // Vector table: COUNT_UP 3, then LOAD 7, then LOAD 12 (rejected)
        for (int k = 0; k < 14; k++) begin
            vecs.push_back(mk((k == 0) || (k == 13), (k == 13) ? OP_LOAD : OP_UP,
                              (k == 13) ? 4'd7 : 4'd3,
                              !(k inside {2, 3, 6, 7, 10, 11}), 1'b1, 1'b0, 1'b0, 4'd0,
                              k == 13, 1'b0, (k == 0) || (k == 13)));
        end
        vecs.push_back(mk(1'b0, OP_LOAD, 4'd7,  1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, OP_LOAD, 4'd7,  1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, OP_LOAD, 4'd7,  1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, OP_LOAD, 4'd12, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, OP_LOAD, 4'd12, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, OP_LOAD, 4'd12, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, OP_LOAD, 4'd12, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1));

        foreach (vecs[i]) begin
            chk1($sformatf("vec%0d_up", i), UP, vecs[i].exp_up);
            chk1($sformatf("vec%0d_dn", i), DN, vecs[i].exp_dn);
            chk1($sformatf("vec%0d_pl", i), PL, vecs[i].exp_pl);
            chk1($sformatf("vec%0d_mr", i), MR, vecs[i].exp_mr);
            chk4($sformatf("vec%0d_d", i), D, vecs[i].exp_d);
            chk1($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
            chk1($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            chk1($sformatf("vec%0d_ready", i), cmd_ready, vecs[i].exp_ready);
            cmd_valid = vecs[i].in_valid;
            cmd_op    = vecs[i].in_op;
            cmd_data  = vecs[i].in_data;
            step();
        end
        cmd_valid = 1'b0;

        // TCU falling edge -> carry_evt three cycles later, for one cycle
        tcu_drv = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk1($sformatf("carry_c%0d", c), carry_evt, c == 3);
            chk1($sformatf("borrow_quiet_c%0d", c), borrow_evt, 1'b0);
        end
        tcu_drv = 1'b1;
        repeat (4) step();
        chk1("carry_no_rise_evt", carry_evt, 1'b0);

        tcd_drv = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk1($sformatf("borrow_c%0d", c), borrow_evt, c == 3);
            chk1($sformatf("carry_quiet_c%0d", c), carry_evt, 1'b0);
        end
        tcd_drv = 1'b1;
        repeat (4) step();

        // COUNT_UP N=0: done next cycle, no pin activity
        send(OP_UP, 4'd0);
        chk1("n0_done", done, 1'b1);
        chk1("n0_ready", cmd_ready, 1'b1);
        chk1("n0_up", UP, 1'b1);
        chk1("n0_dn", DN, 1'b1);
        step();
        chk1("n0_done_clr", done, 1'b0);
        chk1("n0_up_after", UP, 1'b1);

        // CLEAR with cmd_valid held (and op changed) while busy
        cmd_valid = 1'b1;
        cmd_op    = OP_CLEAR;
        cmd_data  = 4'd0;
        step();
        cmd_op   = OP_UP;
        cmd_data = 4'd5;
        chk1("clr_mr_c1", MR, 1'b1);
        chk1("clr_busy_c1", cmd_ready, 1'b0);
        step();
        chk1("clr_mr_c2", MR, 1'b1);
        chk1("clr_busy_c2", cmd_ready, 1'b0);
        step();
        cmd_valid = 1'b0;
        chk1("clr_mr_c3", MR, 1'b0);
        chk1("clr_done_c3", done, 1'b1);
        chk1("clr_ready_c3", cmd_ready, 1'b1);
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (MR || !UP || done) bad = 1'b1;
        end
        chk1("clr_ignored_cmd_quiet", bad, 1'b0);

        // COUNT_DOWN 5 with reset during the 2nd pulse
        send(OP_DOWN, 4'd5);
        repeat (5) step();
        chk1("rstmid_dn_low", DN, 1'b0);
        chk1("rstmid_up_high", UP, 1'b1);
        rst_n = 1'b0;
        step();
        chk1("rstmid_dn_rst", DN, 1'b1);
        chk1("rstmid_up_rst", UP, 1'b1);
        chk1("rstmid_ready_rst", cmd_ready, 1'b0);
        chk1("rstmid_done_rst", done, 1'b0);
        rst_n = 1'b1;
        step();
        chk1("rstmid_ready_rel", cmd_ready, 1'b1);
        chk1("rstmid_dn_rel", DN, 1'b1);
        chk1("rstmid_up_rel", UP, 1'b1);
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (done || !DN || !UP) bad = 1'b1;
        end
        chk1("rstmid_abandoned", bad, 1'b0);

        // Closed loop against the 74192 model
        tc_model = 1'b1;
        repeat (5) step();
        c0 = carry_cnt;
        b0 = borrow_cnt;
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd8);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd9);
        run_closed("cl_clear", OP_CLEAR, 4'd0);
        step();
        run_closed("cl_load8", OP_LOAD, 4'd8);
        step();
        run_closed("cl_up3", OP_UP, 4'd3);
        repeat (6) step();
        chk4("cl_up3_carry_cnt", 4'(carry_cnt - c0), 4'd1);
        chk4("cl_up3_borrow_cnt", 4'(borrow_cnt - b0), 4'd0);
        run_closed("cl_dn2", OP_DOWN, 4'd2);
        repeat (6) step();
        chk4("cl_dn2_carry_cnt", 4'(carry_cnt - c0), 4'd1);
        chk4("cl_dn2_borrow_cnt", 4'(borrow_cnt - b0), 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
